// File: rtl/relu_lane_arbiter.sv
// relu_lane_arbiter: per-lane FIFOs share one ReLU unit through a
// round-robin grant and a registered output, sequenced per layer.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package relu_pkg;
    typedef enum logic {INVALID = 1'b0, VALID = 1'b1} pe_state_e;

    typedef struct packed {
        logic [`CNN_XLEN-1:0] data;
        pe_state_e            PE_state;
    } PE_OUT_PACKET;
endpackage

module relu_lane_arbiter
    import relu_pkg::*;
#(
    parameter int NUM_PE     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WID    = 16,
    parameter int DIV_WID    = `CNN_XLEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  PE_OUT_PACKET              pe_in_pk [NUM_PE],
    output logic [NUM_PE-1:0]         pe_ready,
    input  logic                      layer_start,
    input  logic [CNT_WID-1:0]        layer_cnt,
    input  logic                      pool_stall,
    output PE_OUT_PACKET              relu_in_pk,
    output logic [$clog2(NUM_PE)-1:0] relu_lane,
    output logic                      busy,
    output logic                      layer_done,
    output logic                      overflow_err
);

    localparam int LW = $clog2(NUM_PE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LAST = LW'(NUM_PE - 1);
    localparam logic [LW:0]   NPE  = (LW + 1)'(NUM_PE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e state, state_nxt;

    logic [DIV_WID-1:0] mem [NUM_PE][FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr [NUM_PE];
    logic [AW-1:0]      rd_ptr [NUM_PE];
    logic [CW-1:0]      count [NUM_PE];

    logic [NUM_PE-1:0]  push;
    logic [NUM_PE-1:0]  pop;
    logic [NUM_PE-1:0]  nonempty;
    logic               drop;

    logic [CNT_WID-1:0] remaining;
    logic [LW-1:0]      rr_ptr;
    logic               eligible;
    logic               grant;
    logic [LW-1:0]      gsel;
    logic [LW:0]        scan;
    logic [DIV_WID-1:0] head;

    // Lane status: readiness from the registered count, push/drop decode
    always_comb begin
        pe_ready = '0;
        push     = '0;
        pop      = '0;
        nonempty = '0;
        drop     = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            pe_ready[i] = (count[i] < FULL);
            nonempty[i] = (count[i] != '0);
            push[i]     = (pe_in_pk[i].PE_state == VALID) && pe_ready[i];
            pop[i]      = grant && (gsel == LW'(i));
            if ((pe_in_pk[i].PE_state == VALID) && !pe_ready[i])
                drop = 1'b1;
        end
    end

    // Round-robin search from rr_ptr, first non-empty lane wins
    always_comb begin
        eligible = (state == RUN) && (remaining != '0) && !pool_stall;
        grant    = 1'b0;
        gsel     = '0;
        scan     = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            scan = {1'b0, rr_ptr} + (LW + 1)'(k);
            if (scan >= NPE)
                scan = scan - NPE;
            if (eligible && !grant && nonempty[scan[LW-1:0]]) begin
                grant = 1'b1;
                gsel  = scan[LW-1:0];
            end
        end
    end

    assign head = mem[gsel][rd_ptr[gsel]];

    // Lane FIFO storage; empty slots are never read, so no reset needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= pe_in_pk[i].data;
        end
    end

    // Lane FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PE; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])
                    count[i] <= count[i] + 1'b1;
                else if (pop[i] && !push[i])
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

    // Layer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Layer sequencing: start in IDLE only, finish on the last issue
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (layer_start)
                    state_nxt = (layer_cnt == '0) ? DONE : RUN;
            end
            RUN: begin
                if (grant && (remaining == CNT_WID'(1)))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign layer_done = (state == DONE);

    // Packet budget and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            rr_ptr    <= '0;
        end else begin
            if ((state == IDLE) && layer_start)
                remaining <= layer_cnt;
            else if (grant)
                remaining <= remaining - 1'b1;
            if (grant)
                rr_ptr <= (gsel == LAST) ? '0 : gsel + 1'b1;
        end
    end

    // Registered ReLU feed; a stall yields a bubble, never a replay
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            relu_in_pk.data     <= '0;
            relu_in_pk.PE_state <= INVALID;
            relu_lane           <= '0;
        end else if (grant) begin
            relu_in_pk.data     <= head;
            relu_in_pk.PE_state <= VALID;
            relu_lane           <= gsel;
        end else begin
            relu_in_pk.data     <= '0;
            relu_in_pk.PE_state <= INVALID;
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_err <= 1'b0;
        else if (drop)
            overflow_err <= 1'b1;
    end

endmodule

// File: tb/tb_relu_lane_arbiter.sv
// tb_relu_lane_arbiter: directed steps with hand-computed
// expectations for the shared-ReLU lane arbiter.
module tb_relu_lane_arbiter;
    import relu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    PE_OUT_PACKET pe_in [4];
    logic [3:0]   pe_ready;
    logic         layer_start;
    logic [15:0]  layer_cnt;
    logic         pool_stall;
    PE_OUT_PACKET relu_in_pk;
    logic [1:0]   relu_lane;
    logic         busy;
    logic         layer_done;
    logic         overflow_err;

    int compared = 0;
    int mismatched = 0;

    relu_lane_arbiter #(
        .NUM_PE(4), .FIFO_DEPTH(4), .CNT_WID(16), .DIV_WID(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pe_in_pk(pe_in),
        .pe_ready(pe_ready),
        .layer_start(layer_start),
        .layer_cnt(layer_cnt),
        .pool_stall(pool_stall),
        .relu_in_pk(relu_in_pk),
        .relu_lane(relu_lane),
        .busy(busy),
        .layer_done(layer_done),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [15:0] d, input logic [1:0] l);
        chk({tag, "_valid"}, 32'(relu_in_pk.PE_state), 32'(v));
        chk({tag, "_data"}, 32'(relu_in_pk.data), 32'(d));
        chk({tag, "_lane"}, 32'(relu_lane), 32'(l));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            pe_in[i].data     = '0;
            pe_in[i].PE_state = INVALID;
        end
        layer_start = 1'b0;
    endtask

    task automatic push(input int lane, input logic [15:0] d);
        pe_in[lane].data     = d;
        pe_in[lane].PE_state = VALID;
    endtask

    initial begin
        reset      = 1'b1;
        layer_cnt  = '0;
        pool_stall = 1'b0;
        idle();
        #2;
        chk_out("rst", 1'b0, 16'h0, 2'd0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(layer_done), 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_ready", 32'(pe_ready), 32'hF);
        @(negedge clk);
        reset = 1'b0;

        // round-robin fairness
        layer_cnt = 16'd8;
        layer_start = 1'b1;
        push(0, 16'hA0A0);
        push(1, 16'hB0B0);
        tick();
        chk("rr_busy", 32'(busy), 1);
        chk_out("rr_first", 1'b0, 16'h0, 2'd0);
        layer_start = 1'b0;
        push(0, 16'hA1A1);
        push(1, 16'hB1B1);
        tick();
        chk_out("rr_a0", 1'b1, 16'hA0A0, 2'd0);
        idle();
        tick();
        chk_out("rr_b0", 1'b1, 16'hB0B0, 2'd1);
        tick();
        chk_out("rr_a1", 1'b1, 16'hA1A1, 2'd0);
        tick();
        chk_out("rr_b1", 1'b1, 16'hB1B1, 2'd1);
        chk("rr_nodone", 32'(layer_done), 0);
        tick();
        chk_out("rr_gap", 1'b0, 16'h0, 2'd1);
        chk("rr_busy2", 32'(busy), 1);

        // second start during RUN must not reload the budget of 4
        layer_start = 1'b1;
        layer_cnt = 16'd2;
        push(3, 16'hC0C0);
        tick();
        chk_out("ig_c_first", 1'b0, 16'h0, 2'd1);
        layer_start = 1'b0;
        push(3, 16'hC1C1);
        tick();
        chk_out("ig_c0", 1'b1, 16'hC0C0, 2'd3);
        push(3, 16'hC2C2);
        tick();
        chk_out("ig_c1", 1'b1, 16'hC1C1, 2'd3);
        chk("ig_nodone1", 32'(layer_done), 0);
        push(3, 16'hC3C3);
        tick();
        chk_out("ig_c2", 1'b1, 16'hC2C2, 2'd3);
        chk("ig_nodone2", 32'(layer_done), 0);
        idle();
        tick();
        chk_out("ig_c3", 1'b1, 16'hC3C3, 2'd3);
        chk("ig_done", 32'(layer_done), 1);
        tick();
        chk_out("ig_after", 1'b0, 16'h0, 2'd3);
        chk("ig_done_off", 32'(layer_done), 0);
        chk("ig_busy_off", 32'(busy), 0);

        // layer completion with leftovers on lane 2
        layer_start = 1'b1;
        layer_cnt = 16'd3;
        push(2, 16'hD0D0);
        tick();
        chk_out("lc_first", 1'b0, 16'h0, 2'd3);
        layer_start = 1'b0;
        push(2, 16'hD1D1);
        tick();
        chk_out("lc_d0", 1'b1, 16'hD0D0, 2'd2);
        push(2, 16'hD2D2);
        tick();
        chk_out("lc_d1", 1'b1, 16'hD1D1, 2'd2);
        chk("lc_nodone", 32'(layer_done), 0);
        push(2, 16'hD3D3);
        tick();
        chk_out("lc_d2", 1'b1, 16'hD2D2, 2'd2);
        chk("lc_done", 32'(layer_done), 1);
        push(2, 16'hD4D4);
        tick();
        chk_out("lc_after", 1'b0, 16'h0, 2'd2);
        chk("lc_done_off", 32'(layer_done), 0);
        chk("lc_busy_off", 32'(busy), 0);
        chk("lc_ready", 32'(pe_ready), 32'hF);
        idle();

        // stall mid-stream: lane0 E0,E1 plus leftover D3,D4
        push(0, 16'hE0E0);
        tick();
        push(0, 16'hE1E1);
        tick();
        idle();
        layer_start = 1'b1;
        layer_cnt = 16'd4;
        tick();
        chk("st_busy", 32'(busy), 1);
        chk_out("st_first", 1'b0, 16'h0, 2'd2);
        layer_start = 1'b0;
        tick();
        chk_out("st_e0", 1'b1, 16'hE0E0, 2'd0);
        pool_stall = 1'b1;
        tick();
        chk_out("st_bub1", 1'b0, 16'h0, 2'd0);
        tick();
        chk_out("st_bub2", 1'b0, 16'h0, 2'd0);
        pool_stall = 1'b0;
        tick();
        chk_out("st_d3", 1'b1, 16'hD3D3, 2'd2);
        tick();
        chk_out("st_e1", 1'b1, 16'hE1E1, 2'd0);
        chk("st_nodone", 32'(layer_done), 0);
        tick();
        chk_out("st_d4", 1'b1, 16'hD4D4, 2'd2);
        chk("st_done", 32'(layer_done), 1);
        tick();
        chk("st_busy_off", 32'(busy), 0);

        // zero-count layer
        layer_start = 1'b1;
        layer_cnt = 16'd0;
        tick();
        chk("zc_done", 32'(layer_done), 1);
        chk("zc_busy", 32'(busy), 1);
        chk_out("zc_out", 1'b0, 16'h0, 2'd2);
        layer_start = 1'b0;
        tick();
        chk("zc_done_off", 32'(layer_done), 0);
        chk("zc_busy_off", 32'(busy), 0);
        chk_out("zc_out2", 1'b0, 16'h0, 2'd2);

        // fill lane 0 in IDLE, fifth push overflows
        push(0, 16'hF0F0);
        tick();
        push(0, 16'hF1F1);
        tick();
        push(0, 16'hF2F2);
        tick();
        push(0, 16'hF3F3);
        tick();
        chk("of_ready", 32'(pe_ready), 32'hE);
        chk("of_ovf0", 32'(overflow_err), 0);
        push(0, 16'hF4F4);
        tick();
        chk("of_ovf1", 32'(overflow_err), 1);
        chk("of_ready2", 32'(pe_ready), 32'hE);
        idle();

        // drain with budget 5: only four packets exist
        layer_start = 1'b1;
        layer_cnt = 16'd5;
        tick();
        chk_out("of_first", 1'b0, 16'h0, 2'd2);
        layer_start = 1'b0;
        tick();
        chk_out("of_f0", 1'b1, 16'hF0F0, 2'd0);
        tick();
        chk_out("of_f1", 1'b1, 16'hF1F1, 2'd0);
        tick();
        chk_out("of_f2", 1'b1, 16'hF2F2, 2'd0);
        tick();
        chk_out("of_f3", 1'b1, 16'hF3F3, 2'd0);
        tick();
        chk_out("of_dropped", 1'b0, 16'h0, 2'd0);
        chk("of_busy", 32'(busy), 1);
        chk("of_sticky", 32'(overflow_err), 1);

        // queue G0,G1 behind a stall, then reset mid-layer
        pool_stall = 1'b1;
        push(2, 16'h6060);
        tick();
        chk_out("ar_stall1", 1'b0, 16'h0, 2'd0);
        push(2, 16'h6161);
        tick();
        chk_out("ar_stall2", 1'b0, 16'h0, 2'd0);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk_out("ar_rst", 1'b0, 16'h0, 2'd0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_done", 32'(layer_done), 0);
        chk("ar_ovf", 32'(overflow_err), 0);
        chk("ar_ready", 32'(pe_ready), 32'hF);
        pool_stall = 1'b0;
        #2;
        reset = 1'b0;
        layer_start = 1'b1;
        layer_cnt = 16'd1;
        push(3, 16'h7070);
        tick();
        chk_out("ar_first", 1'b0, 16'h0, 2'd0);
        chk("ar_busy2", 32'(busy), 1);
        idle();
        tick();
        chk_out("ar_h0", 1'b1, 16'h7070, 2'd3);
        chk("ar_done2", 32'(layer_done), 1);
        tick();
        chk_out("ar_end", 1'b0, 16'h0, 2'd3);
        chk("ar_busy_off", 32'(busy), 0);
        chk("ar_ovf2", 32'(overflow_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
